// File: rtl/sha_pkg.sv
// sha_pkg: SHA-256 constants, types and helper functions shared by the compression core
//   state_t    : working state {a,b,c,d,e,f,g,h}, a in the top word
//   fsm_t      : control states of the iterative core
//   K, H0      : round constants and initial hash value
//   s0/s1      : message-schedule sigmas; S0/S1/ch/maj: round functions
//   blk_word   : extracts word i of a 512-bit block (W0 in the top word)
//   legal_rpc  : legal rounds-per-cycle values
package sha_pkg;
   typedef struct packed {
      logic [31:0] a, b, c, d, e, f, g, h;
   } state_t;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   localparam state_t H0 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   function automatic logic [31:0] rotr(logic [31:0] x, int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] s0(logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] s1(logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction
   function automatic logic [31:0] big_s0(logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction
   function automatic logic [31:0] big_s1(logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction
   function automatic logic [31:0] ch(logic [31:0] x, logic [31:0] y, logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction
   function automatic logic [31:0] maj(logic [31:0] x, logic [31:0] y, logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction
   function automatic logic [31:0] blk_word(logic [511:0] b, int i);
      return b[511-32*i -: 32];
   endfunction
   function automatic bit legal_rpc(int r);
      return r inside {1, 2, 4, 8, 16};
   endfunction
endpackage

// File: rtl/sha_round.sv
// sha_round: one combinational SHA-256 round
//   st_i : working state before the round
//   k_i  : round constant K_t
//   w_i  : schedule word W_t
//   st_o : working state after the round
module sha_round
   import sha_pkg::*;
(
   input  state_t      st_i,
   input  logic [31:0] k_i,
   input  logic [31:0] w_i,
   output state_t      st_o
);
   logic [31:0] t1, t2;
   assign t1 = st_i.h + big_s1(st_i.e) + ch(st_i.e, st_i.f, st_i.g) + k_i + w_i;
   assign t2 = big_s0(st_i.a) + maj(st_i.a, st_i.b, st_i.c);
   assign st_o = '{a: t1 + t2, b: st_i.a, c: st_i.b, d: st_i.c,
                   e: st_i.d + t1, f: st_i.e, g: st_i.f, h: st_i.g};
endmodule

// File: rtl/sha_compress_iter.sv
// sha_compress_iter: iterative SHA-256 compression, ROUNDS_PER_CYCLE rounds per clock
//   clk, reset_n          : clock and synchronous active-low reset
//   in_valid/in_ready     : block handshake; in_state = H_in, in_block = W0..W15
//   out_valid/out_ready   : digest handshake; out_digest held until accepted
module sha_compress_iter
   import sha_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit FEED_FORWARD     = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] in_state,
   input  logic [511:0] in_block,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_digest
);
   localparam int R = ROUNDS_PER_CYCLE;
   if (!legal_rpc(R)) begin : g_bad_r
      $error("sha_compress_iter: ROUNDS_PER_CYCLE=%0d is not one of 1,2,4,8,16", R);
   end
   fsm_t         fsm_q;
   logic [5:0]   cnt_q;
   state_t       state_q;
   logic [255:0] h_q;
   logic [31:0]  w_q [16];
   logic [31:0]  w_d [16];
   logic [31:0]  ext [0:15+R];
   state_t       st [0:R];
   logic [255:0] dig_d;
   logic         last;
   assign st[0] = state_q;
   for (genvar i = 0; i < R; i++) begin : g_round
      sha_round u_round (.st_i(st[i]), .k_i(K[cnt_q + 6'(i)]), .w_i(w_q[i]), .st_o(st[i+1]));
   end
   // Window holds W_cnt..W_cnt+15; the R words consumed now are shifted out and
   // R new words are appended, each later one chained off the earlier ones.
   always_comb begin
      for (int j = 0; j < 16; j++) ext[j] = w_q[j];
      for (int i = 0; i < R; i++) ext[16+i] = s1(ext[14+i]) + ext[9+i] + s0(ext[1+i]) + ext[i];
      for (int j = 0; j < 16; j++) w_d[j] = ext[j+R];
   end
   always_comb begin
      dig_d = st[R];
      if (FEED_FORWARD) for (int j = 0; j < 8; j++) dig_d[32*j +: 32] = h_q[32*j +: 32] + st[R][32*j +: 32];
   end
   assign last = ({1'b0, cnt_q} + 7'(R)) == 7'd64;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fsm_q      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_digest <= '0;
         cnt_q      <= '0;
      end else begin
         case (fsm_q)
            IDLE: if (in_valid) begin
               h_q      <= in_state;
               state_q  <= in_state;
               for (int j = 0; j < 16; j++) w_q[j] <= blk_word(in_block, j);
               cnt_q    <= '0;
               in_ready <= 1'b0;
               fsm_q    <= BUSY;
            end
            BUSY: begin
               state_q <= st[R];
               w_q     <= w_d;
               cnt_q   <= cnt_q + 6'(R);
               if (last) begin
                  out_digest <= dig_d;
                  out_valid  <= 1'b1;
                  fsm_q      <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               fsm_q     <= IDLE;
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha_compress_iter.sv
// tb_sha_compress_iter: directed and random checks of sha_compress_iter for every legal R
module tb_sha_compress_iter;
   import sha_pkg::K;
   localparam logic [255:0] IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] ABC_D = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMP_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] RND1  = 256'h5d6aebcd_6a09e667_bb67ae85_3c6ef372_fa2a4622_510e527f_9b05688c_1f83d9ab;
   localparam logic [511:0] ABC_B = {32'h61626380, 448'b0, 32'h00000018};
   localparam logic [511:0] EMP_B = {32'h80000000, 480'b0};
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic         reset_n;
   logic [255:0] in_state;
   logic [511:0] in_block;
   logic         iv [6];
   logic         ir [6];
   logic         ov [6];
   logic         ordy [6];
   logic [255:0] dig [6];
   int n_chk = 0, n_fail = 0;
   for (genvar g = 0; g < 5; g++) begin : gr
      sha_compress_iter #(.ROUNDS_PER_CYCLE(1 << g), .FEED_FORWARD(1)) dut (
         .clk(clk), .reset_n(reset_n), .in_valid(iv[g]), .in_ready(ir[g]),
         .in_state(in_state), .in_block(in_block), .out_valid(ov[g]),
         .out_ready(ordy[g]), .out_digest(dig[g]));
   end
   sha_compress_iter #(.ROUNDS_PER_CYCLE(1), .FEED_FORWARD(0)) dut_nf (
      .clk(clk), .reset_n(reset_n), .in_valid(iv[5]), .in_ready(ir[5]),
      .in_state(in_state), .in_block(in_block), .out_valid(ov[5]),
      .out_ready(ordy[5]), .out_digest(dig[5]));
   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic int lat(int k);
      return k == 5 ? 64 : 64 >> k;
   endfunction
   function automatic logic [31:0] rr(logic [31:0] x, int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   // Straight-line FIPS 180-4 compression: full 64-word schedule, then 64 rounds.
   function automatic logic [255:0] ref_hash(logic [255:0] h, logic [511:0] b, bit ff);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int j = 0; j < 8; j++) v[j] = h[255-32*j -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int j = 0; j < 8; j++) r[255-32*j -: 32] = ff ? v[j] + h[255-32*j -: 32] : v[j];
      return r;
   endfunction
   function automatic logic [511:0] rnd_block();
      logic [511:0] b;
      for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom;
      return b;
   endfunction
   task automatic accept(int k, logic [255:0] s, logic [511:0] b);
      @(negedge clk);
      chk("in_ready_idle", 256'(ir[k]), 1);
      in_state = s;
      in_block = b;
      iv[k] = 1'b1;
      @(posedge clk);
      #1;
      iv[k] = 1'b0;
      in_state = rnd_block()[255:0];
      in_block = rnd_block();
      chk("in_ready_busy", 256'(ir[k]), 0);
   endtask
   task automatic wait_done(int k, int start, logic [255:0] exp, string tag);
      int n = start;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ov[k] && n < 200);
      chk({tag, "_latency"}, 256'(n), 256'(lat(k)));
      chk({tag, "_digest"}, dig[k], exp);
   endtask
   task automatic handshake(int k, string tag);
      ordy[k] = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_out_valid_drop"}, 256'(ov[k]), 0);
      chk({tag, "_in_ready_rise"}, 256'(ir[k]), 1);
   endtask
   task automatic b2b(int k);
      int acc [$];
      logic [255:0] outs [$];
      bit prev = 1'b0;
      int l = lat(k);
      for (int c = 0; c < 2 * l + 8; c++) begin
         @(negedge clk);
         if (acc.size() == 0) begin
            iv[k] = 1'b1; in_state = IV; in_block = ABC_B;
         end else if (c - acc[0] <= l + 1) begin
            iv[k] = 1'($urandom_range(0, 1)); in_state = rnd_block()[255:0]; in_block = rnd_block();
         end else if (acc.size() == 1) begin
            iv[k] = 1'b1; in_state = IV; in_block = EMP_B;
         end else iv[k] = 1'b0;
         if (iv[k] && ir[k]) acc.push_back(c);
         @(posedge clk);
         #1;
         if (ov[k] && !prev) outs.push_back(dig[k]);
         prev = ov[k];
      end
      iv[k] = 1'b0;
      chk("b2b_accepts", 256'(acc.size()), 2);
      chk("b2b_outputs", 256'(outs.size()), 2);
      while (acc.size() < 2) acc.push_back(-1);
      while (outs.size() < 2) outs.push_back('0);
      chk("b2b_spacing", 256'(acc[1] - acc[0]), 256'(l + 2));
      chk("b2b_digest0", outs[0], ABC_D);
      chk("b2b_digest1", outs[1], EMP_D);
   endtask
   initial begin
      logic [255:0] s, nf_exp;
      logic [511:0] b;
      reset_n = 1'b0;
      in_state = '0;
      in_block = '0;
      for (int k = 0; k < 6; k++) begin iv[k] = 1'b0; ordy[k] = 1'b1; end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 6; k++) begin
         chk("reset_in_ready", 256'(ir[k]), 1);
         chk("reset_out_valid", 256'(ov[k]), 0);
         chk("reset_digest", dig[k], 0);
      end
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         accept(k, IV, ABC_B);
         wait_done(k, 0, ABC_D, "abc");
         handshake(k, "abc");
      end
      for (int k = 0; k < 5; k += 4) begin
         accept(k, IV, EMP_B);
         wait_done(k, 0, EMP_D, "empty");
         handshake(k, "empty");
      end
      for (int k = 0; k < 6; k++) begin
         for (int r = 0; r < 2; r++) begin
            s = rnd_block()[255:0];
            b = rnd_block();
            accept(k, s, b);
            wait_done(k, 0, ref_hash(s, b, k != 5), "random");
            handshake(k, "random");
         end
      end
      ordy[2] = 1'b0;
      accept(2, IV, ABC_B);
      wait_done(2, 0, ABC_D, "bp");
      repeat (10) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid_held", 256'(ov[2]), 1);
         chk("bp_digest_held", dig[2], ABC_D);
         chk("bp_in_ready_low", 256'(ir[2]), 0);
      end
      handshake(2, "bp");
      accept(0, IV, ABC_B);
      repeat (32) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midreset_out_valid", 256'(ov[0]), 0);
      chk("midreset_in_ready", 256'(ir[0]), 1);
      reset_n = 1'b1;
      accept(0, IV, ABC_B);
      wait_done(0, 0, ABC_D, "after_reset");
      handshake(0, "after_reset");
      for (int j = 0; j < 8; j++) nf_exp[32*j +: 32] = ABC_D[32*j +: 32] - IV[32*j +: 32];
      accept(5, IV, ABC_B);
      @(posedge clk);
      #1;
      chk("nf_round0_state", dut_nf.state_q, RND1);
      wait_done(5, 1, nf_exp, "nf_abc");
      handshake(5, "nf_abc");
      b2b(0);
      b2b(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
